// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter and single-byte transaction sequencer sharing one I2C master.
// Optional watchdog abort compiled in with `define I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned ADDRWIDTH = 7,
   parameter int unsigned DATAWIDTH = 8,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ-1:0]           req_rw,
   input  logic [NREQ*ADDRWIDTH-1:0] req_addr,
   input  logic [NREQ*DATAWIDTH-1:0] req_wdata,
   output logic [NREQ-1:0]           gnt,
   output logic [NREQ-1:0]           done,
   output logic [DATAWIDTH-1:0]      rdata,
   output logic                      nack,
   output logic                      tmo,
   output logic                      m_enable,
   output logic [ADDRWIDTH-1:0]      m_addr,
   output logic                      m_rw,
   output logic [DATAWIDTH-1:0]      m_wdata,
   input  logic                      m_busy,
   input  logic                      m_done,
   input  logic [DATAWIDTH-1:0]      m_rdata,
   input  logic                      m_nack
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e              state_q;
   logic [PW-1:0]       ptr_q;
   logic [PW-1:0]       winner_q;
   logic [PW-1:0]       pick;
   logic [PW-1:0]       idx;
   logic                pick_vld;
   logic [ADDRWIDTH-1:0] sel_addr;
   logic                sel_rw;
   logic [DATAWIDTH-1:0] sel_wdata;

   // Walk the search order backwards so the first hit after ptr_q is the last one written.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      idx      = '0;
      for (int i = NREQ; i >= 1; i--) begin
         idx = PW'((int'(ptr_q) + i) % int'(NREQ));
         if (req[idx]) begin
            pick     = idx;
            pick_vld = 1'b1;
         end
      end
   end

   always_comb begin
      sel_addr  = '0;
      sel_rw    = 1'b0;
      sel_wdata = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (pick == PW'(k)) begin
            sel_addr  = req_addr[k*ADDRWIDTH +: ADDRWIDTH];
            sel_rw    = req_rw[k];
            sel_wdata = req_wdata[k*DATAWIDTH +: DATAWIDTH];
         end
      end
   end

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   logic [TW-1:0] cnt_q;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         ptr_q    <= PW'(NREQ - 1);
         winner_q <= '0;
         gnt      <= '0;
         done     <= '0;
         rdata    <= '0;
         nack     <= 1'b0;
         tmo      <= 1'b0;
         m_enable <= 1'b0;
         m_addr   <= '0;
         m_rw     <= 1'b0;
         m_wdata  <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
         cnt_q    <= '0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pick_vld) begin
                  state_q     <= StIssue;
                  winner_q    <= pick;
                  gnt         <= '0;
                  gnt[pick]   <= 1'b1;
                  m_enable    <= 1'b1;
                  m_addr      <= sel_addr;
                  m_rw        <= sel_rw;
                  m_wdata     <= sel_wdata;
`ifdef I2C_ARB_TIMEOUT_EN
                  cnt_q       <= '0;
`endif
               end
            end
            StIssue, StWait: begin
`ifdef I2C_ARB_TIMEOUT_EN
               cnt_q <= cnt_q + 1'b1;
`endif
               // Completion outranks both busy and watchdog expiry.
               if (m_done) begin
                  state_q        <= StResp;
                  m_enable       <= 1'b0;
                  done[winner_q] <= 1'b1;
                  rdata          <= m_rw ? m_rdata : '0;
                  nack           <= m_nack;
                  tmo            <= 1'b0;
               end
`ifdef I2C_ARB_TIMEOUT_EN
               else if (cnt_q == TW'(TIMEOUT - 1)) begin
                  state_q        <= StResp;
                  m_enable       <= 1'b0;
                  done[winner_q] <= 1'b1;
                  rdata          <= '0;
                  nack           <= 1'b1;
                  tmo            <= 1'b1;
               end
`endif
               else if (state_q == StIssue && m_busy) begin
                  state_q  <= StWait;
                  m_enable <= 1'b0;
               end
            end
            StResp: begin
               state_q <= StIdle;
               ptr_q   <= winner_q;
               gnt     <= '0;
               done    <= '0;
               rdata   <= '0;
               nack    <= 1'b0;
               tmo     <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/i2c_bus_arbiter.md
# i2c_bus_arbiter

Round-robin arbiter and transaction sequencer that shares a single I2C master datapath among `NREQ` requesters. Each requester presents one single-byte transaction: 7-bit slave address, read/write flag and write data. The arbiter grants one requester, drives the master's enable/address/rw/data inputs and waits for completion. It then returns read data and ACK status to the winner as a one-cycle `done` pulse. It sits between the memory-subsystem clients and the I2C master FSM, in the `clk` domain.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `ADDRWIDTH`, 7, slave address width
- `DATAWIDTH`, 8, data byte width
- `TIMEOUT`, 1024, watchdog limit in `clk` cycles (used only with `I2C_ARB_TIMEOUT_EN`)

- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req`  in  NREQ  per-requester request level
- `req_rw`  in  NREQ  per-requester direction, 1=read, 0=write
- `req_addr`  in  NREQ*ADDRWIDTH  packed slave addresses; requester k in bits [k*ADDRWIDTH +: ADDRWIDTH]
- `req_wdata`  in  NREQ*DATAWIDTH  packed write data, same packing
- `gnt`  out  NREQ  one-hot grant, held from ISSUE through RESP
- `done`  out  NREQ  one-cycle completion pulse to the winner
- `rdata`  out  DATAWIDTH  read byte, valid with `done`; 0 for writes
- `nack`  out  1  slave did not acknowledge, valid with `done`
- `tmo`  out  1  watchdog abort, valid with `done`
- `m_enable`  out  1  start request to the I2C master
- `m_addr`  out  ADDRWIDTH  latched slave address
- `m_rw`  out  1  latched direction
- `m_wdata`  out  DATAWIDTH  latched write data
- `m_busy`  in  1  master has accepted the transaction
- `m_done`  in  1  master completion pulse
- `m_rdata`  in  DATAWIDTH  master read byte, valid with `m_done`
- `m_nack`  in  1  master NACK flag, valid with `m_done`

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req` bit is set, select the winner by round-robin: search starts at `ptr+1` and wraps modulo NREQ.
  - Latch the winner's addr, rw and wdata into `m_*`; set `gnt`; go to ISSUE.
- **ISSUE**
  - `m_enable`=1.
  - On `m_busy`=1: drop `m_enable` and go to WAIT.
  - On `m_done`=1 (busy edge missed): capture and go to RESP.
- **WAIT**
  - `m_enable`=0.
  - On `m_done`: capture `m_nack`; capture `m_rdata` if `m_rw`=1, otherwise capture 0; go to RESP.
- **RESP**
  - `done[winner]`=1 with `rdata`/`nack`/`tmo`; `ptr`=winner.
  - Next cycle: `gnt`=0, `done`=0, go to IDLE.
- A requester holds `req` and its fields until its `done`. Fields are latched at grant, so changes after grant are ignored.
- Deasserting `req` after grant does not abort: the transaction completes and `done` still pulses.
- Arbitration is evaluated only in IDLE. Requests arriving mid-transaction wait.
- Each grant serves exactly one transaction; the requester re-arbitrates for the next one.

## Timing
- Reset values:
  - state=IDLE; `ptr`=NREQ-1, so requester 0 has first priority.
  - All outputs 0: `gnt`, `done`, `rdata`, `nack`, `tmo`, `m_enable`, `m_addr`, `m_rw`, `m_wdata`.
- Latencies and throughput:
  - `req` sampled in IDLE at cycle N gives `gnt` and `m_enable` high at N+1.
  - `m_done` at cycle M gives `done` at M+1.
  - Minimum spacing between successive grants is 1 IDLE cycle after RESP.
- Boundary conditions:
  - Simultaneous requests: exactly one grant.
  - A requester that just finished is lowest priority if others are pending.
  - A single persistent requester is re-granted every transaction.
  - `m_done` together with `m_busy` in ISSUE: the done path has priority (go to RESP).
  - `m_done` in IDLE or RESP is ignored.
  - Reset asserted mid-transaction clears everything immediately and asynchronously. No `done` is issued; the master sees `m_enable` drop.

## Configuration
- Macro: `I2C_ARB_TIMEOUT_EN`.
- **Defined:**
  - A cycle counter clears on entry to ISSUE and increments in ISSUE and WAIT.
  - When it reaches `TIMEOUT`-1 without `m_done`: drop `m_enable`, go to RESP with `tmo`=1, `nack`=1, `rdata`=0.
  - A `m_done` arriving in the same cycle as expiry wins: normal completion, `tmo`=0.
- **Undefined:** no counter; WAIT is held indefinitely; `tmo` is tied to 0.

## Test plan
- Reset, then `req`=0001 write addr 7'h4C data 8'hA5 → `m_enable` one cycle after `req`, `m_addr`=4C, `m_rw`=0, `m_wdata`=A5. Master `m_done` → `done`=0001 next cycle, `rdata`=0, `nack`=0.
- `req`=1111 held for 4 transactions → grants in order 0001, 0010, 0100, 1000, each exactly one-hot.
- Read from requester 2, master returns `m_rdata`=8'h3C with `m_nack`=1 → `done`=0100, `rdata`=3C, `nack`=1.
- Requester 1 drops `req` after grant, before `m_done` → transaction completes and `done[1]` pulses.
- Assert `rst` low while in WAIT → all outputs 0 at once; after release, `req`=1000|0001 → first grant goes to requester 0.
- With `I2C_ARB_TIMEOUT_EN`, `TIMEOUT`=16, master never asserts `m_done` → `done` 16 cycles after entering ISSUE with `tmo`=1, `nack`=1, `m_enable`=0.
